sample_sdram_logger: RTL and testbench



---
 rtl/sample_sdram_logger_if.sv | 24 ++
 rtl/sample_sdram_logger.sv | 148 ++++++++++++++
 tb/tb_sample_sdram_logger.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_sdram_logger_if.sv
// Single-word command port between the sample logger (master) and the SDRAM controller (slave).
interface sample_sdram_logger_if;
    logic        cmd_ready;
    logic        cmd_enable;
    logic        cmd_wr;
    logic [22:0] cmd_address;
    logic [31:0] cmd_data;

    modport master (
        input  cmd_ready,
        output cmd_enable,
        output cmd_wr,
        output cmd_address,
        output cmd_data
    );

    modport slave (
        output cmd_ready,
        input  cmd_enable,
        input  cmd_wr,
        input  cmd_address,
        input  cmd_data
    );
endinterface

// File: rtl/sample_sdram_logger.sv
// Buffers 22-bit sampler words in a FIFO and writes them as 32-bit words to consecutive SDRAM
// addresses. Define SAMPLE_SDRAM_LOGGER_SEQ_TAG_EN to carry a 10-bit sequence tag in bits 31:22.
module sample_sdram_logger #(
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [22:0] BASE_ADDR = 23'h000000,
    parameter logic [22:0] LAST_ADDR = 23'h7FFFFF,
    parameter bit          WRAP      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    output logic                         busy,
    input  logic [21:0]                  sample_data,
    input  logic                         sample_valid,
    sample_sdram_logger_if.master        cmd,
    output logic [22:0]                  words_written,
    output logic                         overflow,
    output logic                         mem_full
);

    localparam int unsigned        DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] IDX_ONE   = FIFO_AW'(1);
    localparam logic [22:0]        MAX_WORDS = 23'h7FFFFF;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_idx_q, rd_idx_q;
    logic [FIFO_AW:0]   count_q;
    logic [22:0]        ptr_q, words_q, addr_q;
    logic [31:0]        data_q, push_word;
    logic               en_q, overflow_q, mem_full_q;
    logic               fifo_full, fifo_empty, start_go, push, drop, issue;
    logic               at_last, hit_end, flush;

    // Full is judged on the registered count, so a same-cycle pop cannot make room.
    always_comb begin
        fifo_full  = (count_q == DEPTH_CNT);
        fifo_empty = (count_q == '0);
        start_go   = (state_q == StIdle) && start;
        push       = (state_q == StRun) && sample_valid && !fifo_full;
        drop       = (state_q == StRun) && sample_valid && fifo_full;
        issue      = (state_q != StIdle) && cmd.cmd_ready && !fifo_empty && !en_q;
        at_last    = (ptr_q == LAST_ADDR);
        hit_end    = issue && at_last && !WRAP;
        flush      = start_go || hit_end;
    end

`ifdef SAMPLE_SDRAM_LOGGER_SEQ_TAG_EN
    logic [9:0] seq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q <= '0;
        end else if (start_go) begin
            seq_q <= '0;
        end else if (push) begin
            seq_q <= seq_q + 10'd1;
        end
    end

    assign push_word = {seq_q, sample_data};
`else
    assign push_word = {10'b0, sample_data};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (stop || hit_end) state_d = StDrain;
            StDrain: if (fifo_empty && !en_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx_q] <= push_word;
    end

    // A flush (start, or end of a non-wrapping region) beats any same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_idx_q <= wr_idx_q + IDX_ONE;
            if (issue) rd_idx_q <= rd_idx_q + IDX_ONE;
            case ({push, issue})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ptr_q      <= BASE_ADDR;
            words_q    <= '0;
            overflow_q <= 1'b0;
            mem_full_q <= 1'b0;
        end else if (start_go) begin
            en_q       <= 1'b0;
            ptr_q      <= BASE_ADDR;
            words_q    <= '0;
            overflow_q <= 1'b0;
            mem_full_q <= 1'b0;
        end else begin
            en_q <= issue;
            if (drop) overflow_q <= 1'b1;
            if (issue) begin
                addr_q  <= ptr_q;
                data_q  <= fifo_mem[rd_idx_q];
                words_q <= (words_q == MAX_WORDS) ? words_q : words_q + 23'd1;
                ptr_q   <= at_last ? BASE_ADDR : ptr_q + 23'd1;
                if (hit_end) mem_full_q <= 1'b1;
            end
        end
    end

    assign busy            = (state_q != StIdle);
    assign cmd.cmd_enable  = en_q;
    assign cmd.cmd_wr      = en_q;
    assign cmd.cmd_address = addr_q;
    assign cmd.cmd_data    = data_q;
    assign words_written   = words_q;
    assign overflow        = overflow_q;
    assign mem_full        = mem_full_q;

endmodule

// File: tb/tb_sample_sdram_logger.sv
// Scoreboard bench for sample_sdram_logger: expected writes are queued as samples are driven
// and popped by per-instance monitors when cmd_enable pulses.
module tb_sample_sdram_logger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start_m = 1'b0, stop_m = 1'b0, start_w = 1'b0, stop_w = 1'b0;
    logic [21:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        busy_m, busy_w1, busy_w0;
    logic [22:0] ww_m, ww_w1, ww_w0;
    logic        ovf_m, ovf_w1, ovf_w0, full_m, full_w1, full_w0;

    sample_sdram_logger_if if_m ();
    sample_sdram_logger_if if_w1 ();
    sample_sdram_logger_if if_w0 ();

    sample_sdram_logger u_dut_m (
        .clk(clk), .rst(rst), .start(start_m), .stop(stop_m), .busy(busy_m),
        .sample_data(sample_data), .sample_valid(sample_valid), .cmd(if_m),
        .words_written(ww_m), .overflow(ovf_m), .mem_full(full_m)
    );

    sample_sdram_logger #(.LAST_ADDR(23'h000003), .WRAP(1'b1)) u_dut_w1 (
        .clk(clk), .rst(rst), .start(start_w), .stop(stop_w), .busy(busy_w1),
        .sample_data(sample_data), .sample_valid(sample_valid), .cmd(if_w1),
        .words_written(ww_w1), .overflow(ovf_w1), .mem_full(full_w1)
    );

    sample_sdram_logger #(.LAST_ADDR(23'h000003), .WRAP(1'b0)) u_dut_w0 (
        .clk(clk), .rst(rst), .start(start_w), .stop(stop_w), .busy(busy_w0),
        .sample_data(sample_data), .sample_valid(sample_valid), .cmd(if_w0),
        .words_written(ww_w0), .overflow(ovf_w0), .mem_full(full_w0)
    );

    int total = 0;
    int bad = 0;

    logic [54:0] q_m[$], q_w1[$], q_w0[$];
    logic [22:0] ptr_m = '0, ptr_w1 = '0;
    logic [9:0]  seq_m = '0, seq_w = '0;
    int          n_w0 = 0;
    bit          run_w = 1'b0;

    function automatic logic [31:0] pack(input logic [9:0] tag, input logic [21:0] d);
`ifdef SAMPLE_SDRAM_LOGGER_SEQ_TAG_EN
        return {tag, d};
`else
        return {10'b0, d} | (32'(tag) & 32'h0);
`endif
    endfunction

    // Main monitor: scoreboard pop plus handshake rules.
    logic prev_en_m = 1'b0, prev_rdy_m = 1'b0;
    always @(negedge clk) begin
        logic [54:0] exp_e;
        if (rst === 1'b1 && if_m.cmd_enable === 1'b1) begin
            total++;
            if (prev_en_m !== 1'b0) begin
                bad++;
                $display("FAIL m_b2b: cmd_enable was %b last cycle, required 0", prev_en_m);
            end
            total++;
            if (prev_rdy_m !== 1'b1) begin
                bad++;
                $display("FAIL m_ready: cmd_ready on issue cycle was %b, required 1", prev_rdy_m);
            end
            total++;
            if (if_m.cmd_wr !== 1'b1) begin
                bad++;
                $display("FAIL m_wr: cmd_wr=%b required 1", if_m.cmd_wr);
            end
            total++;
            if (q_m.size() == 0) begin
                bad++;
                $display("FAIL m_unexpected: write addr=%h data=%h, required none",
                         if_m.cmd_address, if_m.cmd_data);
            end else begin
                exp_e = q_m.pop_front();
                if ({if_m.cmd_address, if_m.cmd_data} !== exp_e) begin
                    bad++;
                    $display("FAIL m_write: addr=%h data=%h, required addr=%h data=%h",
                             if_m.cmd_address, if_m.cmd_data, exp_e[54:32], exp_e[31:0]);
                end
            end
        end
        prev_en_m  = if_m.cmd_enable;
        prev_rdy_m = if_m.cmd_ready;
    end

    always @(negedge clk) begin
        logic [54:0] exp_e;
        if (rst === 1'b1 && if_w1.cmd_enable === 1'b1) begin
            total++;
            if (q_w1.size() == 0) begin
                bad++;
                $display("FAIL w1_unexpected: write addr=%h, required none", if_w1.cmd_address);
            end else begin
                exp_e = q_w1.pop_front();
                if ({if_w1.cmd_address, if_w1.cmd_data} !== exp_e) begin
                    bad++;
                    $display("FAIL w1_write: addr=%h data=%h, required addr=%h data=%h",
                             if_w1.cmd_address, if_w1.cmd_data, exp_e[54:32], exp_e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [54:0] exp_e;
        if (rst === 1'b1 && if_w0.cmd_enable === 1'b1) begin
            total++;
            if (q_w0.size() == 0) begin
                bad++;
                $display("FAIL w0_unexpected: write addr=%h, required none", if_w0.cmd_address);
            end else begin
                exp_e = q_w0.pop_front();
                if ({if_w0.cmd_address, if_w0.cmd_data} !== exp_e) begin
                    bad++;
                    $display("FAIL w0_write: addr=%h data=%h, required addr=%h data=%h",
                             if_w0.cmd_address, if_w0.cmd_data, exp_e[54:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample for the current cycle and records the writes it should cause.
    task automatic drive_sample(input logic [21:0] d, input bit acc_m);
        sample_data  = d;
        sample_valid = 1'b1;
        if (acc_m) begin
            q_m.push_back({ptr_m, pack(seq_m, d)});
            ptr_m++;
            seq_m++;
        end
        if (run_w) begin
            q_w1.push_back({ptr_w1, pack(seq_w, d)});
            ptr_w1 = (ptr_w1 == 23'd3) ? 23'd0 : ptr_w1 + 23'd1;
            if (n_w0 < 4) q_w0.push_back({23'(n_w0), pack(seq_w, d)});
            n_w0++;
            seq_w++;
        end
    endtask

    task automatic start_main();
        start_m = 1'b1;
        ptr_m   = '0;
        seq_m   = '0;
        tick();
        start_m = 1'b0;
    endtask

    task automatic stop_main_and_wait();
        stop_m = 1'b1;
        tick();
        stop_m = 1'b0;
        for (int i = 0; i < 100 && busy_m !== 1'b0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy_m, if_m.cmd_enable, if_m.cmd_wr, ww_m, ovf_m, full_m} !== '0) begin
            bad++;
            $display("FAIL reset_ctl: busy=%b en=%b wr=%b ww=%h ovf=%b full=%b, required all 0",
                     busy_m, if_m.cmd_enable, if_m.cmd_wr, ww_m, ovf_m, full_m);
        end
        total++;
        if ({if_m.cmd_address, if_m.cmd_data} !== '0) begin
            bad++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0", if_m.cmd_address,
                     if_m.cmd_data);
        end
        rst = 1'b1;
        sample_valid = 1'b1;
        stop_m = 1'b1;
        tick();
        sample_valid = 1'b0;
        stop_m = 1'b0;
        repeat (3) tick();
        total++;
        if (busy_m !== 1'b0 || q_m.size() != 0) begin
            bad++;
            $display("FAIL idle_ignore: busy=%b, required 0", busy_m);
        end
    endtask

    task automatic test_basic();
        if_m.cmd_ready = 1'b1;
        sample_data  = 22'h0AAAAA;
        sample_valid = 1'b1;
        start_main();
        sample_valid = 1'b0;
        drive_sample(22'h000001, 1'b1);
        tick();
        total++;
        if (if_m.cmd_enable !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: cmd_enable=%b at N+1, required 0", if_m.cmd_enable);
        end
        drive_sample(22'h000002, 1'b1);
        tick();
        total++;
        if (if_m.cmd_enable !== 1'b1) begin
            bad++;
            $display("FAIL latency_n2: cmd_enable=%b at N+2, required 1", if_m.cmd_enable);
        end
        drive_sample(22'h3FFFFF, 1'b1);
        tick();
        sample_valid = 1'b0;
        stop_main_and_wait();
        total++;
        if (busy_m !== 1'b0 || q_m.size() != 0 || if_m.cmd_enable !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: busy=%b pending=%0d, required 0 and 0", busy_m,
                     q_m.size());
        end
        total++;
        if (ww_m !== 23'd3) begin
            bad++;
            $display("FAIL basic_count: words_written=%0d, required 3", ww_m);
        end
    endtask

    task automatic test_overflow();
        if_m.cmd_ready = 1'b0;
        start_main();
        for (int i = 0; i < 16; i++) begin
            drive_sample(22'h155555 ^ 22'(i * 7), 1'b1);
            tick();
        end
        total++;
        if (ovf_m !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early: overflow=%b after 16 samples, required 0", ovf_m);
        end
        drive_sample(22'h3FFFFE, 1'b0);
        tick();
        sample_valid = 1'b0;
        total++;
        if (ovf_m !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: overflow=%b after 17th sample, required 1", ovf_m);
        end
        if_m.cmd_ready = 1'b1;
        for (int i = 0; i < 100 && q_m.size() != 0; i++) tick();
        repeat (3) tick();
        total++;
        if (q_m.size() != 0 || ww_m !== 23'd16) begin
            bad++;
            $display("FAIL ovf_drain: words_written=%0d pending=%0d, required 16 and 0", ww_m,
                     q_m.size());
        end
        stop_main_and_wait();
        total++;
        if (ovf_m !== 1'b1 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL ovf_sticky: overflow=%b busy=%b, required 1 and 0", ovf_m, busy_m);
        end
    endtask

    task automatic test_handshake();
        bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        if_m.cmd_ready = 1'b0;
        stop_m = 1'b1;
        start_main();
        stop_m = 1'b0;
        total++;
        if (busy_m !== 1'b1 || ovf_m !== 1'b0 || ww_m !== 23'd0) begin
            bad++;
            $display("FAIL start_stop: busy=%b ovf=%b ww=%0d, required 1 0 0", busy_m, ovf_m,
                     ww_m);
        end
        drive_sample(22'h012345, 1'b1);
        tick();
        drive_sample(22'h2ABCDE, 1'b1);
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if_m.cmd_ready = rp[i % 4];
            tick();
        end
        if_m.cmd_ready = 1'b0;
        tick();
        total++;
        if (q_m.size() != 0 || ww_m !== 23'd2) begin
            bad++;
            $display("FAIL handshake: words_written=%0d pending=%0d, required 2 and 0", ww_m,
                     q_m.size());
        end
        stop_main_and_wait();
    endtask

    task automatic test_wrap();
        run_w  = 1'b1;
        ptr_w1 = '0;
        n_w0   = 0;
        seq_w  = '0;
        if_w1.cmd_ready = 1'b1;
        if_w0.cmd_ready = 1'b1;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_sample(22'h300000 + 22'(i), 1'b0);
            tick();
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 100 && (q_w1.size() != 0 || busy_w0 !== 1'b0); i++) tick();
        total++;
        if (q_w1.size() != 0 || q_w0.size() != 0) begin
            bad++;
            $display("FAIL wrap_pending: w1=%0d w0=%0d outstanding, required 0", q_w1.size(),
                     q_w0.size());
        end
        total++;
        if (busy_w0 !== 1'b0 || full_w0 !== 1'b1 || ww_w0 !== 23'd4) begin
            bad++;
            $display("FAIL nowrap_full: busy=%b mem_full=%b ww=%0d, required 0 1 4", busy_w0,
                     full_w0, ww_w0);
        end
        total++;
        if (if_w0.cmd_address !== 23'd3) begin
            bad++;
            $display("FAIL addr_hold: cmd_address=%h, required 3", if_w0.cmd_address);
        end
        total++;
        if (busy_w1 !== 1'b1 || full_w1 !== 1'b0 || ww_w1 !== 23'd6) begin
            bad++;
            $display("FAIL wrap_run: busy=%b mem_full=%b ww=%0d, required 1 0 6", busy_w1,
                     full_w1, ww_w1);
        end
        stop_w = 1'b1;
        tick();
        stop_w = 1'b0;
        run_w  = 1'b0;
        for (int i = 0; i < 50 && busy_w1 !== 1'b0; i++) tick();
        total++;
        if (busy_w1 !== 1'b0) begin
            bad++;
            $display("FAIL wrap_stop: busy=%b, required 0", busy_w1);
        end
    endtask

    task automatic test_reset_mid();
        if_m.cmd_ready = 1'b0;
        start_main();
        for (int i = 0; i < 5; i++) begin
            drive_sample(22'h0F0F00 + 22'(i), 1'b0);
            tick();
        end
        sample_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({busy_m, if_m.cmd_enable, if_m.cmd_wr, if_m.cmd_address, if_m.cmd_data, ww_m,
             ovf_m, full_m} !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b en=%b addr=%h data=%h ww=%h, required all 0",
                     busy_m, if_m.cmd_enable, if_m.cmd_address, if_m.cmd_data, ww_m);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        if_m.cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_valid = i[0];
            tick();
        end
        sample_valid = 1'b0;
        total++;
        if (ww_m !== 23'd0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: ww=%0d busy=%b, required 0 and 0", ww_m, busy_m);
        end
    endtask

`ifdef SAMPLE_SDRAM_LOGGER_SEQ_TAG_EN
    task automatic test_seq_tag();
        if_m.cmd_ready = 1'b0;
        start_main();
        for (int i = 0; i < 16; i++) begin
            drive_sample(22'(i), 1'b1);
            tick();
        end
        drive_sample(22'd16, 1'b0);
        tick();
        sample_valid = 1'b0;
        if_m.cmd_ready = 1'b1;
        repeat (6) tick();
        for (int i = 17; i < 1026; i++) begin
            drive_sample(22'(i), 1'b1);
            tick();
            sample_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 200 && q_m.size() != 0; i++) tick();
        total++;
        if (q_m.size() != 0 || ww_m !== 23'd1025) begin
            bad++;
            $display("FAIL seq_count: ww=%0d pending=%0d, required 1025 and 0", ww_m,
                     q_m.size());
        end
        stop_main_and_wait();
    endtask
`endif

    initial begin
        if_m.cmd_ready  = 1'b0;
        if_w1.cmd_ready = 1'b0;
        if_w0.cmd_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_handshake();
        test_wrap();
        test_reset_mid();
`ifdef SAMPLE_SDRAM_LOGGER_SEQ_TAG_EN
        test_seq_tag();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
